// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DBG and data-memory signals of the data-memory arbiter.
interface dmem_arbiter_if #(parameter int DATA_WIDTH = 32);
  logic                  cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic                  dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [DATA_WIDTH-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic                  mem_read, mem_write;
  logic [DATA_WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
           dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
           dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata, mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
           dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data memory arbitration between CPU and DBG with starvation guard and DBG lock.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {ARB, LOCKED} state_t;
  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          pend_v, pend_dbg, hold, starved, cpu_gnt, dbg_gnt, mem_read;
  // lock is level-sensitive: dropping it restores normal arbitration in the same cycle
  assign hold     = (state == LOCKED) && bus.dbg_lock;
  assign starved  = starve_cnt == SW'(STARVE_LIMIT);
  assign dbg_gnt  = bus.dbg_req & (hold | ~bus.cpu_req | starved);
  assign cpu_gnt  = bus.cpu_req & ~hold & ~dbg_gnt;
  assign mem_read = (cpu_gnt & ~bus.cpu_we) | (dbg_gnt & ~bus.dbg_we);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      pend_v     <= 1'b0;
      pend_dbg   <= 1'b0;
    end else begin
      state      <= (dbg_gnt & bus.dbg_lock) ? LOCKED : ARB;
      starve_cnt <= (bus.dbg_req & ~dbg_gnt) ? (starved ? starve_cnt : starve_cnt + SW'(1)) : '0;
      pend_v     <= mem_read;
      pend_dbg   <= dbg_gnt;
    end
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = (cpu_gnt & bus.cpu_we) | (dbg_gnt & bus.dbg_we);
  assign bus.mem_addr   = dbg_gnt ? bus.dbg_addr : cpu_gnt ? bus.cpu_addr : {DATA_WIDTH{1'b0}};
  assign bus.mem_wdata  = dbg_gnt ? bus.dbg_wdata : cpu_gnt ? bus.cpu_wdata : {DATA_WIDTH{1'b0}};
  assign bus.cpu_rvalid = pend_v & ~pend_dbg;
  assign bus.dbg_rvalid = pend_v & pend_dbg;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, hand corner sequences and randomized traffic against a reference model.
module tb_dmem_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.DATA_WIDTH(32)) bus();
  dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIM)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw, dl; logic [31:0] da, dd, mr;
    logic e_cg, e_dg, e_st, e_mr, e_mw; logic [31:0] e_ma, e_md;
    logic e_cv; logic [31:0] e_crd; logic e_dv; logic [31:0] e_drd;
  } vec_t;
  vec_t tbl[13];
  bit m_locked;
  int m_denied;
  int pend_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_raw(input logic cr, cw, input logic [31:0] ca, cd,
                         input logic dr, dw, dl, input logic [31:0] da, dd, mr);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_lock = dl; bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.mem_rdata = mr;
  endtask
  task automatic idle(input logic [31:0] mr);
    set_raw(0, 0, 0, 0, 0, 0, 0, 0, 0, mr);
  endtask
  task automatic model_reset();
    m_locked = 0;
    m_denied = 0;
    pend_q.delete();
  endtask
  function automatic void model_grants(output bit g_cpu, output bit g_dbg);
    bit excl = m_locked && bus.dbg_lock;
    g_dbg = bus.dbg_req && (excl || !bus.cpu_req || m_denied >= LIM);
    g_cpu = bus.cpu_req && !excl && !g_dbg;
  endfunction
  task automatic model_check();
    bit gc, gd, rd;
    logic [31:0] ea, ed;
    model_grants(gc, gd);
    rd = (gc && !bus.cpu_we) || (gd && !bus.dbg_we);
    ea = gd ? bus.dbg_addr : gc ? bus.cpu_addr : 32'h0;
    ed = gd ? bus.dbg_wdata : gc ? bus.cpu_wdata : 32'h0;
    chk("cpu_gnt", bus.cpu_gnt, 32'(gc));
    chk("dbg_gnt", bus.dbg_gnt, 32'(gd));
    chk("cpu_stall", bus.cpu_stall, 32'(bus.cpu_req && !gc));
    chk("mem_read", bus.mem_read, 32'(rd));
    chk("mem_write", bus.mem_write, 32'((gc || gd) && !rd));
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    chk("cpu_rvalid", bus.cpu_rvalid, 32'(pend_q.size() > 0 && pend_q[0] == 0));
    chk("dbg_rvalid", bus.dbg_rvalid, 32'(pend_q.size() > 0 && pend_q[0] == 1));
    chk("cpu_rdata", bus.cpu_rdata, (pend_q.size() > 0 && pend_q[0] == 0) ? bus.mem_rdata : 32'h0);
    chk("dbg_rdata", bus.dbg_rdata, (pend_q.size() > 0 && pend_q[0] == 1) ? bus.mem_rdata : 32'h0);
  endtask
  task automatic advance();
    bit gc, gd;
    model_grants(gc, gd);
    @(posedge clk);
    pend_q.delete();
    if (gc && !bus.cpu_we) pend_q.push_back(0);
    if (gd && !bus.dbg_we) pend_q.push_back(1);
    m_locked = gd && bus.dbg_lock;
    m_denied = (bus.dbg_req && !gd) ? ((m_denied + 1 > LIM) ? LIM : m_denied + 1) : 0;
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{0,0,0,0,             0,0,0,0,0,                   0,           0,0,0,0,0,0,0,                      0,0,0,0};
    tbl[1]  = '{1,0,'h10,0,          0,0,0,0,0,                   0,           1,0,0,1,0,'h10,0,                   0,0,0,0};
    tbl[2]  = '{0,0,0,0,             0,0,0,0,0,                   'hA5A50001,  0,0,0,0,0,0,0,                      1,'hA5A50001,0,0};
    tbl[3]  = '{1,1,'h14,'h1234,     0,0,0,0,0,                   0,           1,0,0,0,1,'h14,'h1234,              0,0,0,0};
    tbl[4]  = '{0,0,0,0,             0,0,0,0,0,                   'hFFFF,      0,0,0,0,0,0,0,                      0,0,0,0};
    tbl[5]  = '{1,0,'h30,0,          0,0,0,0,0,                   0,           1,0,0,1,0,'h30,0,                   0,0,0,0};
    tbl[6]  = '{0,0,0,0,             1,0,0,'h40,0,                'h11,        0,1,0,1,0,'h40,0,                   1,'h11,0,0};
    tbl[7]  = '{0,0,0,0,             0,0,0,0,0,                   'h22,        0,0,0,0,0,0,0,                      0,0,1,'h22};
    tbl[8]  = '{0,0,0,0,             1,1,1,'h20,'hDEADBEEF,       0,           0,1,0,0,1,'h20,'hDEADBEEF,          0,0,0,0};
    tbl[9]  = '{1,0,'h50,0,          1,1,1,'h20,'hDEADBEEF,       0,           0,1,1,0,1,'h20,'hDEADBEEF,          0,0,0,0};
    tbl[10] = '{1,0,'h50,0,          1,1,1,'h20,'hDEADBEEF,       0,           0,1,1,0,1,'h20,'hDEADBEEF,          0,0,0,0};
    tbl[11] = '{1,0,'h50,0,          1,1,0,'h20,'hDEADBEEF,       0,           1,0,0,1,0,'h50,0,                   0,0,0,0};
    tbl[12] = '{0,0,0,0,             0,0,0,0,0,                   'h33,        0,0,0,0,0,0,0,                      1,'h33,0,0};
    idle(0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_raw(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].dl,
              tbl[i].da, tbl[i].dd, tbl[i].mr);
      #1;
      chk($sformatf("v%0d cpu_gnt", i), bus.cpu_gnt, 32'(tbl[i].e_cg));
      chk($sformatf("v%0d dbg_gnt", i), bus.dbg_gnt, 32'(tbl[i].e_dg));
      chk($sformatf("v%0d cpu_stall", i), bus.cpu_stall, 32'(tbl[i].e_st));
      chk($sformatf("v%0d mem_read", i), bus.mem_read, 32'(tbl[i].e_mr));
      chk($sformatf("v%0d mem_write", i), bus.mem_write, 32'(tbl[i].e_mw));
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, tbl[i].e_ma);
      chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tbl[i].e_md);
      chk($sformatf("v%0d cpu_rvalid", i), bus.cpu_rvalid, 32'(tbl[i].e_cv));
      chk($sformatf("v%0d cpu_rdata", i), bus.cpu_rdata, tbl[i].e_crd);
      chk($sformatf("v%0d dbg_rvalid", i), bus.dbg_rvalid, 32'(tbl[i].e_dv));
      chk($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata, tbl[i].e_drd);
      advance();
    end
    for (int i = 0; i < 10; i++) begin
      set_raw(1, 0, 'h100, 0, 1, 0, 0, 'h200, 0, $urandom);
      #1;
      chk($sformatf("starve%0d dbg_gnt", i), bus.dbg_gnt, 32'(i % 5 == 4));
      chk($sformatf("starve%0d cpu_stall", i), bus.cpu_stall, 32'(i % 5 == 4));
      model_check();
      advance();
    end
    idle($urandom);
    #1;
    model_check();
    advance();
    for (int i = 0; i < 2; i++) begin
      set_raw(1, 0, 'h100, 0, 1, 0, 0, 'h200, 0, 0);
      advance();
    end
    set_raw(1, 0, 'h60, 0, 1, 0, 0, 'h200, 0, 'h5555);
    #1;
    chk("rst_pre cpu_gnt", bus.cpu_gnt, 1);
    #1;
    rst_n = 1'b0;
    idle('h5555);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_in cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_in dbg_rvalid", bus.dbg_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_out cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_out mem_read", bus.mem_read, 0);
    advance();
    for (int i = 0; i < 5; i++) begin
      set_raw(1, 1, 'h70, 'h1, 1, 1, 0, 'h80, 'h2, 0);
      #1;
      chk($sformatf("post_rst%0d dbg_gnt", i), bus.dbg_gnt, 32'(i == 4));
      model_check();
      advance();
    end
    for (int i = 0; i < 600; i++) begin
      set_raw($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom_range(0, 255), $urandom, $urandom);
      #1;
      model_check();
      advance();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
